// File: rtl/construtor_caminho_controlador_if.sv
// Path-reconstruction bus bundle.
// Groups the predecessor-memory read port and the valid/ready path stream.
//   master: the path constructor (drives read strobe/address and the stream beat)
//   slave : memory + consumer side (drives read data/valid and stream ready)
interface construtor_caminho_controlador_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_rd_en_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [ADDR_W-1:0] mem_data_in;
  logic              mem_valido_in;
  logic              caminho_valid_out;
  logic [ADDR_W-1:0] caminho_no_out;
  logic              caminho_ready_in;

  modport master (
    output mem_rd_en_out, mem_addr_out, caminho_valid_out, caminho_no_out,
    input  mem_data_in, mem_valido_in, caminho_ready_in
  );

  modport slave (
    input  mem_rd_en_out, mem_addr_out, caminho_valid_out, caminho_no_out,
    output mem_data_in, mem_valido_in, caminho_ready_in
  );
endinterface

// File: rtl/construtor_caminho_controlador.sv
// Path reconstruction sequencer.
// Walks the predecessor memory from destino back to fonte, one read per node,
// streaming every node (destino first) over a valid/ready port, then reports
// completion (caminho_pronto_out) or a broken chain (erro_out) until lido_in.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   iniciar_in          start pulse, latches fonte_in / destino_in
//   lido_in             consumer acknowledge of pronto/erro
//   bus (master)        predecessor memory read port + path stream
//   aguardando_out      idle indicator
//   caminho_pronto_out  path complete (held until lido_in)
//   erro_out            chain broken (held until lido_in)
//   tamanho_out         number of accepted beats
// Configuration macro: CONSTRUTOR_LIMITE_EN enables the MAX_LEN chain-length guard.
module construtor_caminho_controlador #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned LEN_W   = 9
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               iniciar_in,
  input  logic [ADDR_W-1:0]                  fonte_in,
  input  logic [ADDR_W-1:0]                  destino_in,
  input  logic                               lido_in,
  construtor_caminho_controlador_if.master   bus,
  output logic                               aguardando_out,
  output logic                               caminho_pronto_out,
  output logic                               erro_out,
  output logic [LEN_W-1:0]                   tamanho_out
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] EMITIR = 3'd1;
  localparam logic [2:0] LER    = 3'd2;
  localparam logic [2:0] ESPERA = 3'd3;
  localparam logic [2:0] PRONTO = 3'd4;
  localparam logic [2:0] ERRO   = 3'd5;

`ifdef CONSTRUTOR_LIMITE_EN
  localparam bit LIMITE_EN = 1'b1;
`else
  localparam bit LIMITE_EN = 1'b0;
`endif
  localparam logic [LEN_W-1:0] LIMITE = LEN_W'(MAX_LEN);

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] atual, atual_n;
  logic [ADDR_W-1:0] fonte, fonte_n;
  logic [LEN_W-1:0]  tamanho_n, tamanho_inc;

  // Next-state and datapath update; a start pulse overrides everything.
  always_comb begin
    state_n     = state;
    atual_n     = atual;
    fonte_n     = fonte;
    tamanho_n   = tamanho_out;
    tamanho_inc = tamanho_out + LEN_W'(1);
    if (iniciar_in) begin
      fonte_n   = fonte_in;
      atual_n   = destino_in;
      tamanho_n = '0;
      state_n   = EMITIR;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        // valid is high for the whole EMITIR stay, so ready alone completes the beat
        EMITIR: begin
          if (bus.caminho_ready_in) begin
            tamanho_n = tamanho_inc;
            if (atual == fonte) begin
              state_n = PRONTO;
            end else if (LIMITE_EN && (tamanho_inc == LIMITE)) begin
              state_n = ERRO;
            end else begin
              state_n = LER;
            end
          end
        end
        LER: state_n = ESPERA;
        ESPERA: begin
          if (!bus.mem_valido_in) begin
            state_n = ERRO;
          end else begin
            atual_n = bus.mem_data_in;
            state_n = EMITIR;
          end
        end
        PRONTO, ERRO: begin
          if (lido_in) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, datapath and outputs; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= IDLE;
      atual                 <= '0;
      fonte                 <= '0;
      tamanho_out           <= '0;
      aguardando_out        <= 1'b1;
      caminho_pronto_out    <= 1'b0;
      erro_out              <= 1'b0;
      bus.caminho_valid_out <= 1'b0;
      bus.caminho_no_out    <= '0;
      bus.mem_rd_en_out     <= 1'b0;
      bus.mem_addr_out      <= '0;
    end else begin
      state                 <= state_n;
      atual                 <= atual_n;
      fonte                 <= fonte_n;
      tamanho_out           <= tamanho_n;
      aguardando_out        <= (state_n == IDLE);
      caminho_pronto_out    <= (state_n == PRONTO);
      erro_out              <= (state_n == ERRO);
      bus.caminho_valid_out <= (state_n == EMITIR);
      bus.caminho_no_out    <= (state_n == EMITIR) ? atual_n : ADDR_W'(0);
      bus.mem_rd_en_out     <= (state_n == LER);
      bus.mem_addr_out      <= (state_n == LER) ? atual_n : ADDR_W'(0);
    end
  end

endmodule

// File: tb/tb_construtor_caminho_controlador.sv
// Self-checking bench for construtor_caminho_controlador: directed scenarios
// plus random predecessor chains checked against a path-list reference model.
module tb_construtor_caminho_controlador;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned LEN_W   = 9;

`ifdef CONSTRUTOR_LIMITE_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              iniciar_in = 1'b0;
  logic [ADDR_W-1:0] fonte_in = '0;
  logic [ADDR_W-1:0] destino_in = '0;
  logic              lido_in = 1'b0;
  logic              aguardando_out;
  logic              caminho_pronto_out;
  logic              erro_out;
  logic [LEN_W-1:0]  tamanho_out;

  construtor_caminho_controlador_if #(.ADDR_W(ADDR_W)) bus ();

  construtor_caminho_controlador #(
    .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .iniciar_in        (iniciar_in),
    .fonte_in          (fonte_in),
    .destino_in        (destino_in),
    .lido_in           (lido_in),
    .bus               (bus),
    .aguardando_out    (aguardando_out),
    .caminho_pronto_out(caminho_pronto_out),
    .erro_out          (erro_out),
    .tamanho_out       (tamanho_out)
  );

  always #5 clk = ~clk;

  logic [ADDR_W-1:0] pred [256];
  logic              vld  [256];

  int n_assert = 0;
  int n_fail   = 0;

  // Predecessor memory: answers one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en_out) begin
      bus.mem_data_in   <= pred[bus.mem_addr_out];
      bus.mem_valido_in <= vld[bus.mem_addr_out];
    end else begin
      bus.mem_data_in   <= 8'($urandom);
      bus.mem_valido_in <= 1'b0;
    end
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Reference: expected beat list, error flag and read count from the chain rules.
  logic [ADDR_W-1:0] exp_q[$];
  bit                exp_err;
  int                exp_rd;

  function automatic void model(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] d);
    logic [ADDR_W-1:0] node;
    node = d;
    exp_q.delete();
    exp_err = 1'b0;
    exp_rd  = 0;
    for (int k = 0; k < 1000; k++) begin
      exp_q.push_back(node);
      if (node == f) begin
        exp_rd = exp_q.size() - 1;
        return;
      end
      if (LIM && (exp_q.size() == int'(MAX_LEN))) begin
        exp_err = 1'b1;
        exp_rd  = exp_q.size() - 1;
        return;
      end
      if (!vld[node]) begin
        exp_err = 1'b1;
        exp_rd  = exp_q.size();
        return;
      end
      node = pred[node];
    end
  endfunction

  // mode: 0 random ready, 1 ready always high, 2 stall 3 cycles on node 2
  task automatic run_walk(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] d, input int mode, input string tag);
    logic [ADDR_W-1:0] got[$];
    logic [ADDR_W-1:0] last_acc, stall_no;
    int  cyc, rd_cnt, stall_cnt;
    bit  fin, stalled, rdy;
    cyc = 0; rd_cnt = 0; stall_cnt = 0; fin = 1'b0; stalled = 1'b0;
    last_acc = '0; stall_no = '0;
    model(f, d);
    @(negedge clk);
    fonte_in = f; destino_in = d; iniciar_in = 1'b1; bus.caminho_ready_in = 1'b0;
    @(negedge clk);
    iniciar_in = 1'b0;
    chk(tag, "start_tamanho", 32'(tamanho_out), 32'd0);
    chk(tag, "start_no", 32'(bus.caminho_no_out), 32'(d));
    while (!fin && cyc < 300) begin
      cyc++;
      if (caminho_pronto_out || erro_out) begin
        fin = 1'b1;
      end else begin
        if (stalled) begin
          chk(tag, "stall_valid", 32'(bus.caminho_valid_out), 32'd1);
          chk(tag, "stall_no", 32'(bus.caminho_no_out), 32'(stall_no));
          chk(tag, "stall_rd", 32'(bus.mem_rd_en_out), 32'd0);
        end
        if (bus.mem_rd_en_out) begin
          rd_cnt++;
          chk(tag, "rd_addr", 32'(bus.mem_addr_out), 32'(last_acc));
        end else begin
          chk(tag, "addr_idle", 32'(bus.mem_addr_out), 32'd0);
        end
        if (mode == 1) rdy = 1'b1;
        else if (mode == 2) begin
          rdy = 1'b1;
          if (bus.caminho_valid_out && bus.caminho_no_out == 8'd2 && stall_cnt < 3) begin
            rdy = 1'b0;
            stall_cnt++;
          end
        end else rdy = ($urandom_range(0, 3) != 0);
        bus.caminho_ready_in = rdy;
        if (bus.caminho_valid_out && rdy) begin
          got.push_back(bus.caminho_no_out);
          last_acc = bus.caminho_no_out;
        end
        stalled  = bus.caminho_valid_out && !rdy;
        stall_no = bus.caminho_no_out;
        @(negedge clk);
      end
    end
    chk(tag, "finished", 32'(fin), 32'd1);
    chk(tag, "n_beats", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(tag, $sformatf("beat%0d", i), 32'(got[i]), 32'(exp_q[i]));
    chk(tag, "pronto", 32'(caminho_pronto_out), 32'(!exp_err));
    chk(tag, "erro", 32'(erro_out), 32'(exp_err));
    chk(tag, "tamanho", 32'(tamanho_out), 32'(exp_q.size()));
    chk(tag, "reads", 32'(rd_cnt), 32'(exp_rd));
    if (mode == 1 && !exp_err)
      chk(tag, "cycles", 32'(cyc), 32'(3 * exp_q.size() - 1));
    if (mode == 2)
      chk(tag, "stalls", 32'(stall_cnt), 32'd3);
    bus.caminho_ready_in = 1'b0;
    lido_in = 1'b1;
    @(negedge clk);
    lido_in = 1'b0;
    chk(tag, "idle_aguardando", 32'(aguardando_out), 32'd1);
    chk(tag, "idle_flags", 32'({caminho_pronto_out, erro_out}), 32'd0);
    chk(tag, "idle_tamanho", 32'(tamanho_out), 32'(exp_q.size()));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      pred[i] = 8'($urandom);
      vld[i]  = 1'b0;
    end
  endtask

  // Random acyclic chain of L distinct nodes; optionally broken at one link.
  task automatic rand_chain(output logic [ADDR_W-1:0] f, output logic [ADDR_W-1:0] d);
    logic [ADDR_W-1:0] n[6];
    bit used[256];
    int L;
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    clear_mem();
    L = $urandom_range(1, 6);
    for (int i = 0; i < L; i++) begin
      do n[i] = 8'($urandom); while (used[n[i]]);
      used[n[i]] = 1'b1;
    end
    for (int i = 0; i < L - 1; i++) begin
      pred[n[i]] = n[i + 1];
      vld[n[i]]  = 1'b1;
    end
    if (L > 1 && $urandom_range(0, 3) == 0)
      vld[n[$urandom_range(0, L - 2)]] = 1'b0;
    d = n[0];
    f = n[L - 1];
  endtask

  initial begin
    logic [ADDR_W-1:0] rf, rd;
    bus.caminho_ready_in = 1'b0;
    clear_mem();

    // T1 reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("T1", "aguardando", 32'(aguardando_out), 32'd1);
    chk("T1", "flags", 32'({caminho_pronto_out, erro_out, bus.caminho_valid_out, bus.mem_rd_en_out}), 32'd0);
    chk("T1", "tamanho", 32'(tamanho_out), 32'd0);
    chk("T1", "no_addr", 32'({bus.caminho_no_out, bus.mem_addr_out}), 32'd0);
    rst_n = 1'b1;

    // T2 full chain 3->2->1->0
    pred[3] = 8'd2; vld[3] = 1'b1;
    pred[2] = 8'd1; vld[2] = 1'b1;
    pred[1] = 8'd0; vld[1] = 1'b1;
    run_walk(8'd0, 8'd3, 1, "T2");

    // T3 fonte == destino
    run_walk(8'd5, 8'd5, 1, "T3");

    // T5 backpressure on beat 2
    run_walk(8'd0, 8'd3, 2, "T5");

    // T4 broken link at node 2
    vld[2] = 1'b0;
    run_walk(8'd0, 8'd3, 1, "T4");
    vld[2] = 1'b1;

    // T6 self-loop at node 3
    pred[3] = 8'd3; vld[3] = 1'b1;
`ifdef CONSTRUTOR_LIMITE_EN
    run_walk(8'd0, 8'd3, 1, "T6lim");
`endif
    @(negedge clk);
    fonte_in = 8'd0; destino_in = 8'd3; iniciar_in = 1'b1;
    @(negedge clk);
    iniciar_in = 1'b0;
    bus.caminho_ready_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (bus.caminho_valid_out) chk("T6", "loop_no", 32'(bus.caminho_no_out), 32'd3);
      @(negedge clk);
    end
    bus.caminho_ready_in = 1'b0;
    chk("T6", "mid_tamanho", 32'(tamanho_out), 32'd3);
    fonte_in = 8'd5; destino_in = 8'd5; iniciar_in = 1'b1;
    @(negedge clk);
    iniciar_in = 1'b0;
    chk("T6", "restart_valid", 32'(bus.caminho_valid_out), 32'd1);
    chk("T6", "restart_no", 32'(bus.caminho_no_out), 32'd5);
    chk("T6", "restart_tamanho", 32'(tamanho_out), 32'd0);
    bus.caminho_ready_in = 1'b1;
    @(negedge clk);
    bus.caminho_ready_in = 1'b0;
    chk("T6", "restart_pronto", 32'(caminho_pronto_out), 32'd1);
    chk("T6", "restart_len", 32'(tamanho_out), 32'd1);
    lido_in = 1'b1;
    @(negedge clk);
    lido_in = 1'b0;

    // Random chains with random backpressure
    for (int t = 0; t < 25; t++) begin
      rand_chain(rf, rd);
      run_walk(rf, rd, 0, $sformatf("R%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
